alu_arbiter: RTL and testbench

//  Shares one registered-output ALU among NUM_REQ requesters, one operation at a time.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu_arbiter_rr_grant.sv | 32 +++
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// State encoding, ALU op codes and an index-width helper.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  localparam logic [1:0] MUX_IMM = 2'd1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// One-hot grant over a valid vector, searching upward from ptr.
// A pointer held at zero degenerates to fixed lowest-index priority.
module rr_grant
  import alu_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] win
);

  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-output ALU among NUM_REQ requesters.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*CTRL_W-1:0] req_control,
  input  logic [NUM_REQ*2-1:0]      req_mux,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [CTRL_W-1:0]         alu_control,
  output logic [1:0]                alu_mux,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  input  logic [NUM_REQ-1:0]        rsp_ready
);

  localparam int PW = idx_w(NUM_REQ);

  state_t               state;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   owner;
  logic [PW-1:0]        win;
  logic [PW-1:0]        ptr;
  logic                 accept;

  rr_grant #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .win   (win)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      alu_mux     <= '0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a       <= req_a[win*DATA_W +: DATA_W];
            alu_b       <= req_b[win*DATA_W +: DATA_W];
            alu_control <= req_control[win*CTRL_W +: CTRL_W];
            alu_mux     <= req_mux[win*2 +: 2];
            owner       <= grant;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        // ALU zero flag lags one op, so zero is derived from the captured value
        CAPTURE: begin
          rsp_result <= alu_result;
          rsp_zero   <= (alu_result == '0);
          rsp_valid  <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (|(rsp_ready & owner)) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU.
// Grant-order expectations follow ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 2;
  localparam int W = 32;
  localparam int C = 4;
  localparam logic [31:0] IMM = 32'd543254;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N*C-1:0]   req_control = '0;
  logic [N*2-1:0]   req_mux = '0;
  logic [W-1:0]     alu_a, alu_b, alu_result;
  logic [C-1:0]     alu_control;
  logic [1:0]       alu_mux;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_result;
  logic             rsp_zero;
  logic [N-1:0]     rsp_ready = '0;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .CTRL_W(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_control (req_control),
    .req_mux     (req_mux),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_mux     (alu_mux),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_ready   (rsp_ready)
  );

  function automatic logic [31:0] alu_f(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] c, input logic [1:0] m);
    if (m == MUX_IMM) return a + IMM;
    case (c)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alu_result <= '0;
    else     alu_result <= alu_f(alu_a, alu_b, alu_control, alu_mux);
  end

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic send(input int id, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] c,
                      input logic [1:0] m, output bit ok);
    @(posedge clk); #1;
    req_a[id*W +: W]       = a;
    req_b[id*W +: W]       = b;
    req_control[id*C +: C] = c;
    req_mux[id*2 +: 2]     = m;
    req_valid[id]          = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic release_rsp(input int id);
    rsp_ready[id] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_zero} !== '0 || rsp_result !== '0 ||
        {alu_a, alu_b, alu_control, alu_mux} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b rv=%b res=%h z=%b a=%h b=%h c=%h m=%h want all 0",
               req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_control, alu_mux);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    bit ok; int n; exp_t e;
    sb.push_back('{0, 32'd12, 1'b0});
    send(0, 32'd5, 32'd7, OP_ADD, 2'd0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL add_accept: no grant for req0"); end
    wait_rsp(n);
    e = sb.pop_front();
    total++;
    if (n !== 3) begin bad++; $display("FAIL add_latency: got %0d want 3", n); end
    total++;
    if (rsp_valid !== onehot(e.id)) begin
      bad++; $display("FAIL add_rsp_valid: got %b want %b", rsp_valid, onehot(e.id));
    end
    total++;
    if (rsp_result !== e.res || rsp_zero !== e.z) begin
      bad++; $display("FAIL add_result: got %0d/%b want %0d/%b", rsp_result, rsp_zero, e.res, e.z);
    end
    release_rsp(0);
  endtask

  task automatic test_sub_zero();
    bit ok; int n; exp_t e;
    sb.push_back('{1, 32'd0, 1'b1});
    send(1, 32'd9, 32'd9, OP_SUB, 2'd0, ok);
    wait_rsp(n);
    e = sb.pop_front();
    total++;
    if (!ok || n !== 3 || rsp_valid !== onehot(e.id)) begin
      bad++; $display("FAIL sub_rsp_valid: ok=%b lat=%0d got %b want %b", ok, n, rsp_valid, onehot(e.id));
    end
    total++;
    if (rsp_result !== e.res || rsp_zero !== e.z) begin
      bad++; $display("FAIL sub_result: got %0d/%b want %0d/%b", rsp_result, rsp_zero, e.res, e.z);
    end
    release_rsp(1);
    @(negedge clk);
    total++;
    if (alu_a !== 32'd9 || alu_b !== 32'd9 || alu_control !== OP_SUB || alu_mux !== 2'd0) begin
      bad++; $display("FAIL alu_hold: got a=%0d b=%0d c=%h m=%h want 9 9 6 0", alu_a, alu_b, alu_control, alu_mux);
    end
  endtask

  task automatic test_imm_mode();
    bit ok; int n; exp_t e;
    sb.push_back('{0, 32'd543264, 1'b0});
    send(0, 32'd10, 32'd0, OP_ADD, MUX_IMM, ok);
    wait_rsp(n);
    e = sb.pop_front();
    total++;
    if (!ok || rsp_valid !== onehot(e.id) || rsp_result !== e.res || rsp_zero !== e.z) begin
      bad++; $display("FAIL imm_result: ok=%b rv=%b got %0d/%b want %0d/%b",
                      ok, rsp_valid, rsp_result, rsp_zero, e.res, e.z);
    end
    release_rsp(0);
  endtask

  task automatic test_arbitration();
    int expg[4]; logic [N-1:0] got; int n; exp_t e;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    expg = '{0, 1, 0, 1};
`else
    expg = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_a       = {32'd100, 32'd1};
    req_b       = {32'd200, 32'd2};
    req_control = {OP_ADD, OP_ADD};
    req_mux     = '0;
    req_valid   = 2'b11;
    rsp_ready   = 2'b11;
    for (int g = 0; g < 4; g++) begin
      got = '0;
      for (int k = 0; k < 20 && got == '0; k++) begin
        @(negedge clk);
        got = req_ready;
      end
      total++;
      if (got !== onehot(expg[g])) begin
        bad++; $display("FAIL arb_grant%0d: got %b want %b", g, got, onehot(expg[g]));
      end
      sb.push_back('{expg[g], (expg[g] == 0) ? 32'd3 : 32'd300, 1'b0});
      wait_rsp(n);
      e = sb.pop_front();
      total++;
      if (rsp_valid !== onehot(e.id) || rsp_result !== e.res) begin
        bad++; $display("FAIL arb_rsp%0d: got %b/%0d want %b/%0d",
                        g, rsp_valid, rsp_result, onehot(e.id), e.res);
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    bit ok; int n; exp_t e;
    sb.push_back('{0, 32'h0000_00FF, 1'b0});
    send(0, 32'h0000_00F0, 32'h0000_000F, OP_OR, 2'd0, ok);
    wait_rsp(n);
    e = sb.pop_front();
    total++;
    if (!ok || rsp_result !== e.res) begin
      bad++; $display("FAIL bp_result: ok=%b got %h want %h", ok, rsp_result, e.res);
    end
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b01 || rsp_result !== e.res || req_ready !== 2'b00) begin
        bad++; $display("FAIL bp_hold%0d: rv=%b res=%h rdy=%b want 01 %h 00",
                        k, rsp_valid, rsp_result, req_ready, e.res);
      end
    end
    rsp_ready[1] = 1'b0;
    release_rsp(0);
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
      bad++; $display("FAIL bp_release: rv=%b rdy=%b want 00 10", rsp_valid, req_ready);
    end
    req_valid[1] = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    bit ok; int n; exp_t e; logic seen;
    send(1, 32'd3, 32'd4, OP_ADD, 2'd0, ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_zero} !== '0 || rsp_result !== '0 ||
        {alu_a, alu_b, alu_control, alu_mux} !== '0) begin
      bad++; $display("FAIL midreset_outputs: rdy=%b rv=%b res=%h z=%b a=%h b=%h want 0",
                      req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== '0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midreset_norsp: got rsp_valid want none"); end
    sb.push_back('{0, 32'd15, 1'b0});
    send(0, 32'd20, 32'd5, OP_SUB, 2'd0, ok);
    wait_rsp(n);
    e = sb.pop_front();
    total++;
    if (!ok || n !== 3 || rsp_valid !== onehot(e.id) || rsp_result !== e.res || rsp_zero !== e.z) begin
      bad++; $display("FAIL midreset_fresh: ok=%b lat=%0d rv=%b got %0d want %0d",
                      ok, n, rsp_valid, rsp_result, e.res);
    end
    release_rsp(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_imm_mode();
    test_arbitration();
    test_backpressure();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
